// File: rtl/seq_game_pkg.sv
// Shared types for the note-sequence memory game: FSM state encoding and note type.
package seq_game_pkg;

  localparam int PKG_NOTE_W = 4;

  typedef logic [PKG_NOTE_W-1:0] note_t;

  localparam note_t SILENT = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEMO_ON  = 3'd1,
    DEMO_GAP = 3'd2,
    LISTEN   = 3'd3,
    QUIZ     = 3'd4,
    DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_memory_game_if.sv
// Player/sequence inputs and piezo/LED/status outputs of the memory game engine.
// The score signal exists only when SEQ_GAME_SCORE_EN is defined.
interface seq_memory_game_if #(
  parameter int NOTE_W    = 4,
  parameter int SEQ_DEPTH = 8
);

  localparam int LEN_W = $clog2(SEQ_DEPTH + 1);

  logic                        load_valid;
  logic [NOTE_W*SEQ_DEPTH-1:0] load_data;
  logic                        ans_valid;
  logic [NOTE_W-1:0]           ans_note;
  logic [NOTE_W-1:0]           piezo_note;
  logic [NOTE_W-1:0]           led_note;
  logic                        miss;
  logic                        level_up;
  logic [2:0]                  state_out;
  logic                        tick_out;
  logic [LEN_W-1:0]            cur_len;
`ifdef SEQ_GAME_SCORE_EN
  logic [7:0]                  score;
`endif

  modport master (
    output load_valid, load_data, ans_valid, ans_note,
    input  piezo_note, led_note, miss, level_up, state_out, tick_out, cur_len
`ifdef SEQ_GAME_SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  load_valid, load_data, ans_valid, ans_note,
    output piezo_note, led_note, miss, level_up, state_out, tick_out, cur_len
`ifdef SEQ_GAME_SCORE_EN
    , output score
`endif
  );

endinterface

// File: rtl/game_tick_gen.sv
// Free-running game tick: one-cycle pulse every TICK_DIV clocks, restartable by a sync clear.
module game_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_memory_game.sv
// Note-sequence memory game engine: demo a growing prefix, check answers, then a timed quiz pass.
// Optional feature macro: SEQ_GAME_SCORE_EN adds a saturating correct-answer counter on bus.score.
module seq_memory_game
  import seq_game_pkg::*;
#(
  parameter int NOTE_W     = 4,
  parameter int SEQ_DEPTH  = 8,
  parameter int TICK_DIV   = 5_000_000,
  parameter int START_LEN  = 3,
  parameter int TONE_TICKS = 2,
  parameter int GAP_TICKS  = 1,
  parameter int ANS_TICKS  = 2
) (
  input logic              clk,
  input logic              reset,
  seq_memory_game_if.slave bus
);

  localparam int LEN_W = $clog2(SEQ_DEPTH + 1);
  localparam int IDX_W = $clog2(SEQ_DEPTH);
  localparam int TCW   = 8;

  seq_state_t        state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [TCW-1:0]    tcnt, tcnt_n;
  logic              answered, answered_n;
  logic [NOTE_W-1:0] seq [SEQ_DEPTH];
  logic [NOTE_W-1:0] cur_note, sel_note;
  logic              tick, clear;
  logic              miss_d, level_d;
  logic [NOTE_W-1:0] piezo_d, led_d;
  logic [NOTE_W-1:0] piezo_q, led_q;
  logic              miss_q, level_q, tick_q;
  logic [LEN_W-1:0]  len_q;

  assign cur_note = seq[idx];
  assign clear    = (state_n != state) || bus.load_valid;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // State, sequence store and registered outputs; outputs are computed from next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= LEN_W'(START_LEN);
      tcnt     <= '0;
      answered <= 1'b0;
      for (int i = 0; i < SEQ_DEPTH; i++) seq[i] <= '0;
      piezo_q  <= '0;
      led_q    <= '0;
      miss_q   <= 1'b0;
      level_q  <= 1'b0;
      tick_q   <= 1'b0;
      len_q    <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      tcnt     <= tcnt_n;
      answered <= answered_n;
      if (bus.load_valid) begin
        for (int i = 0; i < SEQ_DEPTH; i++) seq[i] <= bus.load_data[i*NOTE_W +: NOTE_W];
      end
      piezo_q  <= piezo_d;
      led_q    <= led_d;
      miss_q   <= miss_d;
      level_q  <= level_d;
      tick_q   <= tick;
      len_q    <= len_n;
    end
  end

  // Next-state logic; a load overrides everything, answers are only judged in LISTEN/QUIZ
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    len_n      = len;
    tcnt_n     = tcnt;
    answered_n = answered;
    miss_d     = 1'b0;
    level_d    = 1'b0;
    if (bus.load_valid) begin
      state_n    = (|bus.load_data) ? DEMO_ON : IDLE;
      idx_n      = '0;
      len_n      = LEN_W'(START_LEN);
      answered_n = 1'b0;
    end else begin
      case (state)
        DEMO_ON: begin
          if (tick) begin
            if (tcnt == TCW'(TONE_TICKS - 1)) state_n = DEMO_GAP;
            else tcnt_n = tcnt + 1'b1;
          end
        end
        DEMO_GAP: begin
          if (tick) begin
            if (tcnt == TCW'(GAP_TICKS - 1)) begin
              if (LEN_W'(idx) + 1'b1 == len) begin
                idx_n   = '0;
                state_n = LISTEN;
              end else begin
                idx_n   = idx + 1'b1;
                state_n = DEMO_ON;
              end
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        LISTEN: begin
          if (bus.ans_valid) begin
            if (bus.ans_note != cur_note) begin
              miss_d  = 1'b1;
              idx_n   = '0;
              state_n = DEMO_ON;
            end else if (LEN_W'(idx) + 1'b1 < len) begin
              idx_n = idx + 1'b1;
            end else if (len < LEN_W'(SEQ_DEPTH)) begin
              len_n   = len + 1'b1;
              level_d = 1'b1;
              idx_n   = '0;
              state_n = DEMO_ON;
            end else begin
              idx_n   = '0;
              state_n = QUIZ;
            end
          end
        end
        QUIZ: begin
          if (bus.ans_valid && !answered) begin
            answered_n = 1'b1;
            if (bus.ans_note != cur_note) miss_d = 1'b1;
          end
          // Window close: a note that never got an answer counts as a miss
          if (tick) begin
            if (tcnt == TCW'(ANS_TICKS - 1)) begin
              tcnt_n     = '0;
              answered_n = 1'b0;
              if (!answered && !bus.ans_valid) miss_d = 1'b1;
              if (idx == IDX_W'(SEQ_DEPTH - 1)) begin
                idx_n   = '0;
                state_n = DONE;
              end else begin
                idx_n = idx + 1'b1;
              end
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (clear) tcnt_n = '0;
  end

  // Output decode for the cycle after this edge; a load always restarts at note 0 of the new data
  always_comb begin
    piezo_d  = NOTE_W'(SILENT);
    led_d    = NOTE_W'(SILENT);
    sel_note = bus.load_valid ? bus.load_data[NOTE_W-1:0] : seq[idx_n];
    case (state_n)
      DEMO_ON: begin
        piezo_d = sel_note;
        led_d   = sel_note;
      end
      QUIZ: led_d = sel_note;
      LISTEN: begin
        if (state == LISTEN) led_d = bus.ans_valid ? bus.ans_note : led_q;
      end
      default: ;
    endcase
  end

  assign bus.piezo_note = piezo_q;
  assign bus.led_note   = led_q;
  assign bus.miss       = miss_q;
  assign bus.level_up   = level_q;
  assign bus.state_out  = state;
  assign bus.tick_out   = tick_q;
  assign bus.cur_len    = len_q;

`ifdef SEQ_GAME_SCORE_EN
  logic       correct;
  logic [7:0] score_q;

  always_comb begin
    correct = !bus.load_valid && bus.ans_valid && (bus.ans_note == cur_note) &&
              ((state == LISTEN) || (state == QUIZ && !answered));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (bus.load_valid) begin
      score_q <= '0;
    end else if (correct && score_q != 8'hFF) begin
      score_q <= score_q + 1'b1;
    end
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_seq_memory_game.sv
// Self-checking bench for seq_memory_game: directed vector table, reset corners, random play vs model.
module tb_seq_memory_game;
  import seq_game_pkg::*;

  localparam int NW = 4, SD = 4, TD = 4, SL = 2, TONE = 2, GAP = 1, ANS = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seq_memory_game_if #(.NOTE_W(NW), .SEQ_DEPTH(SD)) bus ();

  seq_memory_game #(
    .NOTE_W(NW), .SEQ_DEPTH(SD), .TICK_DIV(TD), .START_LEN(SL),
    .TONE_TICKS(TONE), .GAP_TICKS(GAP), .ANS_TICKS(ANS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: durations counted in clocks, game rules applied directly
  int m_state, m_len, m_idx, m_clk, m_tickph, m_score, m_curlen, m_led;
  bit m_answered, m_miss, m_lvl, m_tick;
  int m_seq [SD];

  task automatic modelReset();
    m_state = 0; m_len = SL; m_idx = 0; m_clk = 0; m_tickph = 0; m_score = 0;
    m_curlen = 0; m_led = 0; m_answered = 0; m_miss = 0; m_lvl = 0; m_tick = 0;
    for (int i = 0; i < SD; i++) m_seq[i] = 0;
  endtask

  task automatic modelStep(input bit ld, input logic [15:0] d, input bit av, input logic [3:0] an);
    int prev;
    prev   = m_state;
    m_tick = (m_tickph == TD - 1);
    m_miss = 0;
    m_lvl  = 0;
    if (ld) begin
      for (int i = 0; i < SD; i++) m_seq[i] = (d >> (i * NW)) & 4'hF;
      m_len = SL; m_idx = 0; m_score = 0; m_answered = 0;
      m_state = (d != 0) ? 1 : 0;
    end else begin
      case (m_state)
        1: begin
          m_clk++;
          if (m_clk == TONE * TD) m_state = 2;
        end
        2: begin
          m_clk++;
          if (m_clk == GAP * TD) begin
            m_idx++;
            if (m_idx == m_len) begin m_idx = 0; m_state = 3; m_led = 0; end
            else m_state = 1;
          end
        end
        3: if (av) begin
          if (int'(an) != m_seq[m_idx]) begin
            m_miss = 1; m_idx = 0; m_state = 1;
          end else begin
            m_score++;
            if (m_idx < m_len - 1) begin m_idx++; m_led = an; end
            else if (m_len < SD) begin m_len++; m_lvl = 1; m_idx = 0; m_state = 1; end
            else begin m_idx = 0; m_state = 4; end
          end
        end
        4: begin
          m_clk++;
          if (av && !m_answered) begin
            m_answered = 1;
            if (int'(an) == m_seq[m_idx]) m_score++;
            else m_miss = 1;
          end
          if (m_clk == ANS * TD) begin
            if (!m_answered) m_miss = 1;
            m_answered = 0; m_clk = 0;
            if (m_idx == SD - 1) begin m_idx = 0; m_state = 5; end
            else m_idx++;
          end
        end
        default: ;
      endcase
    end
    if (ld || m_state != prev) begin m_tickph = 0; m_clk = 0; end
    else m_tickph = (m_tickph + 1) % TD;
    if (m_score > 255) m_score = 255;
    m_curlen = m_len;
  endtask

  task automatic checkOutput(input string name);
    int ePz, eLed;
    ePz  = (m_state == 1) ? m_seq[m_idx] : 0;
    eLed = (m_state == 1 || m_state == 4) ? m_seq[m_idx] : ((m_state == 3) ? m_led : 0);
    checks++;
    if (bus.piezo_note !== 4'(ePz) || bus.led_note !== 4'(eLed) || bus.miss !== m_miss ||
        bus.level_up !== m_lvl || bus.state_out !== 3'(m_state) || bus.tick_out !== m_tick ||
        bus.cur_len !== 3'(m_curlen)) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got st=%0d pz=%0d led=%0d miss=%0b lvl=%0b tick=%0b len=%0d, want st=%0d pz=%0d led=%0d miss=%0b lvl=%0b tick=%0b len=%0d",
               name, $time, bus.state_out, bus.piezo_note, bus.led_note, bus.miss, bus.level_up,
               bus.tick_out, bus.cur_len, m_state, ePz, eLed, m_miss, m_lvl, m_tick, m_curlen);
    end
`ifdef SEQ_GAME_SCORE_EN
    checks++;
    if (bus.score !== 8'(m_score)) begin
      errors++;
      $display("[TB] FAIL %s_score: got %0d want %0d", name, bus.score, m_score);
    end
`endif
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] d, input bit av, input logic [3:0] an);
    bus.load_valid = ld;
    bus.load_data  = d;
    bus.ans_valid  = av;
    bus.ans_note   = an;
    @(posedge clk);
    modelStep(ld, d, av, an);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.ans_valid  = 1'b0;
    checkOutput("model");
  endtask

  typedef struct {
    string       name;
    bit          ld;
    logic [15:0] d;
    bit          av;
    logic [3:0]  an;
    int          ncyc;
    int          st, pz, led, len;
    bit          miss, lvl;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  function automatic void addVec(input string nm, input bit ld, input logic [15:0] d, input bit av,
                                 input logic [3:0] an, input int ncyc, input int st, input int pz,
                                 input int led, input int len, input bit miss, input bit lvl);
    vecs[nvec] = '{nm, ld, d, av, an, ncyc, st, pz, led, len, miss, lvl};
    nvec++;
  endfunction

  task automatic checkVec(input vec_t v);
    checks++;
    if (bus.state_out !== 3'(v.st) || bus.piezo_note !== 4'(v.pz) || bus.led_note !== 4'(v.led) ||
        bus.cur_len !== 3'(v.len) || bus.miss !== v.miss || bus.level_up !== v.lvl) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d pz=%0d led=%0d len=%0d miss=%0b lvl=%0b, want st=%0d pz=%0d led=%0d len=%0d miss=%0b lvl=%0b",
               v.name, bus.state_out, bus.piezo_note, bus.led_note, bus.cur_len, bus.miss,
               bus.level_up, v.st, v.pz, v.led, v.len, v.miss, v.lvl);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if (bus.piezo_note !== 4'd0 || bus.led_note !== 4'd0 || bus.miss !== 1'b0 ||
        bus.level_up !== 1'b0 || bus.state_out !== 3'd0 || bus.tick_out !== 1'b0 ||
        bus.cur_len !== 3'd0) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d pz=%0d led=%0d miss=%0b lvl=%0b tick=%0b len=%0d, want all 0",
               name, bus.state_out, bus.piezo_note, bus.led_note, bus.miss, bus.level_up,
               bus.tick_out, bus.cur_len);
    end
  endtask

  initial begin
    bit          ld, av;
    logic [15:0] d;
    logic [3:0]  an;

    // Level-up path from a fresh load
    addVec("A_load",      1, 16'h4321, 0, 0,  1, 1, 1, 1, 2, 0, 0);
    addVec("A_tone_hold", 0, 0,        0, 0,  7, 1, 1, 1, 2, 0, 0);
    addVec("A_gap",       0, 0,        0, 0,  1, 2, 0, 0, 2, 0, 0);
    addVec("A_note2",     0, 0,        0, 0,  4, 1, 2, 2, 2, 0, 0);
    addVec("A_gap2",      0, 0,        0, 0,  8, 2, 0, 0, 2, 0, 0);
    addVec("A_listen",    0, 0,        0, 0,  4, 3, 0, 0, 2, 0, 0);
    addVec("A_ans1",      0, 0,        1, 1,  1, 3, 0, 1, 2, 0, 0);
    addVec("A_levelup",   0, 0,        1, 2,  1, 1, 1, 1, 3, 0, 1);
    addVec("A_lvl_pulse", 0, 0,        0, 0,  1, 1, 1, 1, 3, 0, 0);
    addVec("A_note3",     0, 0,        0, 0, 23, 1, 3, 3, 3, 0, 0);
    addVec("A_listen3",   0, 0,        0, 0, 12, 3, 0, 0, 3, 0, 0);
    // Miss path after a reload from LISTEN
    addVec("B_reload",    1, 16'h4321, 0, 0,  1, 1, 1, 1, 2, 0, 0);
    addVec("B_listen",    0, 0,        0, 0, 24, 3, 0, 0, 2, 0, 0);
    addVec("B_ans1",      0, 0,        1, 1,  1, 3, 0, 1, 2, 0, 0);
    addVec("B_miss",      0, 0,        1, 5,  1, 1, 1, 1, 2, 1, 0);
    addVec("B_miss_end",  0, 0,        0, 0,  1, 1, 1, 1, 2, 0, 0);
    addVec("B_replay2",   0, 0,        0, 0, 11, 1, 2, 2, 2, 0, 0);
    addVec("B_listen2",   0, 0,        0, 0, 12, 3, 0, 0, 2, 0, 0);
    // Climb to full length and the quiz pass
    addVec("C_a1",        0, 0,        1, 1,  1, 3, 0, 1, 2, 0, 0);
    addVec("C_lvl3",      0, 0,        1, 2,  1, 1, 1, 1, 3, 0, 1);
    addVec("C_listen3",   0, 0,        0, 0, 36, 3, 0, 0, 3, 0, 0);
    addVec("C_b1",        0, 0,        1, 1,  1, 3, 0, 1, 3, 0, 0);
    addVec("C_b2",        0, 0,        1, 2,  1, 3, 0, 2, 3, 0, 0);
    addVec("C_lvl4",      0, 0,        1, 3,  1, 1, 1, 1, 4, 0, 1);
    addVec("C_listen4",   0, 0,        0, 0, 48, 3, 0, 0, 4, 0, 0);
    addVec("C_c1",        0, 0,        1, 1,  1, 3, 0, 1, 4, 0, 0);
    addVec("C_c2",        0, 0,        1, 2,  1, 3, 0, 2, 4, 0, 0);
    addVec("C_c3",        0, 0,        1, 3,  1, 3, 0, 3, 4, 0, 0);
    addVec("C_quiz",      0, 0,        1, 4,  1, 4, 0, 1, 4, 0, 0);
    addVec("Q_ans1",      0, 0,        1, 1,  1, 4, 0, 1, 4, 0, 0);
    addVec("Q_note2",     0, 0,        0, 0,  7, 4, 0, 2, 4, 0, 0);
    addVec("Q_expire",    0, 0,        0, 0,  8, 4, 0, 3, 4, 1, 0);
    addVec("Q_ans3",      0, 0,        1, 3,  1, 4, 0, 3, 4, 0, 0);
    addVec("Q_note4",     0, 0,        0, 0,  7, 4, 0, 4, 4, 0, 0);
    addVec("Q_wrong9",    0, 0,        1, 9,  1, 4, 0, 4, 4, 1, 0);
    addVec("Q_done",      0, 0,        0, 0,  7, 5, 0, 0, 4, 0, 0);
    // Reload while a demo note is sounding, then an all-silent load
    addVec("D_load",      1, 16'h4321, 0, 0,  1, 1, 1, 1, 2, 0, 0);
    addVec("D_mid_tone",  0, 0,        0, 0,  3, 1, 1, 1, 2, 0, 0);
    addVec("D_reload",    1, 16'h0065, 0, 0,  1, 1, 5, 5, 2, 0, 0);
    addVec("D_full_tone", 0, 0,        0, 0,  7, 1, 5, 5, 2, 0, 0);
    addVec("D_gap",       0, 0,        0, 0,  1, 2, 0, 0, 2, 0, 0);
    addVec("D_silent",    1, 16'h0000, 0, 0,  1, 0, 0, 0, 2, 0, 0);

    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.ans_valid = 1'b0; bus.ans_note = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkZero("reset_state");
    reset = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].av, vecs[i].an);
      for (int c = 1; c < vecs[i].ncyc; c++) applyStimulus(1'b0, '0, 1'b0, '0);
      checkVec(vecs[i]);
    end

    // Reset while a wrong answer is being sampled in LISTEN: no miss pulse may escape
    applyStimulus(1'b1, 16'h4321, 1'b0, '0);
    repeat (23) applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 4'd1);
    bus.ans_valid = 1'b1;
    bus.ans_note  = 4'd7;
    #2 reset = 1'b1;
    #1 checkZero("reset_async");
    @(posedge clk);
    #1 checkZero("reset_no_pulse");
    bus.ans_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checks++;
    if (bus.cur_len !== 3'(SL) || bus.state_out !== 3'd0) begin
      errors++;
      $display("[TB] FAIL post_reset: got len=%0d st=%0d want len=%0d st=0", bus.cur_len, bus.state_out, SL);
    end

    // Random play, mostly correct answers so the game advances
    applyStimulus(1'b1, 16'h8A5F, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      ld = ($urandom_range(0, 299) == 0);
      d  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) d = '0;
      av = ($urandom_range(0, 3) == 0);
      an = ($urandom_range(0, 9) < 8) ? 4'(m_seq[m_idx]) : 4'($urandom_range(0, 15));
      applyStimulus(ld, d, av, an);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
